voice_alloc: RTL and testbench

- Parametrised successor to the combinational key priority decoder for the synth front end.
- Takes synchronised key levels and tracks each key's press and release edges.
- Assigns newly pressed keys to a pool of NUM_VOICES oscillator voices, stealing the oldest voice when all are busy.
- Sits between the key synchroniser and the per-voice note-to-frequency/oscillator blocks; replaces the fixed two-note (high/low) scheme.

---
 rtl/sass_voice_pkg.sv | 15 +
 rtl/lsb_pri_enc.sv | 23 ++
 rtl/voice_alloc.sv | 141 ++++++++++++++
 tb/tb_voice_alloc.sv | 123 ++++++++++++
 4 files changed

// File: rtl/sass_voice_pkg.sv
// Shared types for the synth voice allocator: note codes and per-voice state.
package sass_voice_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned AGE_W  = 4;

    typedef logic [NOTE_W-1:0] note_t;

    typedef struct packed {
        logic               on;
        note_t              note;
        logic [AGE_W-1:0]   age;
    } voice_t;

endpackage

// File: rtl/lsb_pri_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module lsb_pri_enc #(
    parameter int unsigned W = 8,
    localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan downwards so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: edge-detects keys, queues presses and assigns
// them to voices, freeing on release and stealing the oldest voice when full.
module voice_alloc
    import sass_voice_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 14,
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned STEAL_EN   = 1,
    localparam int unsigned KEY_W     = $clog2(NUM_KEYS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         keys_i,
    output logic [NUM_VOICES*KEY_W-1:0] voice_note_o,
    output logic [NUM_VOICES-1:0]       voice_on_o,
    output logic [NUM_VOICES-1:0]       voice_trig_o,
    output logic                        steal_o,
    output logic                        overflow_o
);

    localparam int unsigned VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned NOTE_SPAN = 1 << NOTE_W;
    localparam logic        STEAL     = (STEAL_EN != 0);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    logic [NUM_KEYS-1:0]   prev_q, pend_q, pend_d;
    voice_t                voice_q [NUM_VOICES];
    voice_t                voice_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic                  steal_q, steal_d;
    logic                  ovf_q, ovf_d;

    logic [NUM_KEYS-1:0]   rise, owned, cand, svc;
    logic [NOTE_SPAN-1:0]  keys_pad;
    logic [NUM_VOICES-1:0] released, free;
    logic [KEY_W-1:0]      key_idx;
    logic                  key_vld;
    logic [VIDX_W-1:0]     free_idx, old_idx, target;
    logic                  free_vld, alloc;
    logic [AGE_W-1:0]      old_age;

    lsb_pri_enc #(.W(NUM_KEYS)) u_key_enc (
        .req   (cand),
        .idx   (key_idx),
        .valid (key_vld)
    );

    lsb_pri_enc #(.W(NUM_VOICES)) u_free_enc (
        .req   (free),
        .idx   (free_idx),
        .valid (free_vld)
    );

    // Edge detect, ownership guard, release detection and candidate set.
    always_comb begin
        keys_pad = NOTE_SPAN'(keys_i);
        rise     = keys_i & ~prev_q;
        owned    = '0;
        released = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            released[v] = voice_q[v].on & ~keys_pad[voice_q[v].note];
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (voice_q[v].on && !released[v] && voice_q[v].note == NOTE_W'(k)) begin
                    owned[k] = 1'b1;
                end
            end
        end
        cand = (pend_q | rise) & keys_i & ~owned;
        free = released;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!voice_q[v].on) free[v] = 1'b1;
        end
    end

    // Oldest sounding voice, ties resolved to the lowest index.
    always_comb begin
        old_idx = '0;
        old_age = voice_q[0].age;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (voice_q[v].age > old_age) begin
                old_idx = VIDX_W'(v);
                old_age = voice_q[v].age;
            end
        end
    end

    // Allocation decision and next voice state.
    always_comb begin
        alloc   = key_vld & (free_vld | STEAL);
        target  = free_vld ? free_idx : old_idx;
        steal_d = key_vld & ~free_vld & STEAL;
        svc     = key_vld ? (NUM_KEYS'(1) << key_idx) : '0;
        pend_d  = cand & ~svc;
        ovf_d   = $countones(keys_i) > NUM_VOICES;
        trig_d  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_d[v] = voice_q[v];
            if (released[v]) voice_d[v].on = 1'b0;
            if (alloc) begin
                if (target == VIDX_W'(v)) begin
                    voice_d[v].on   = 1'b1;
                    voice_d[v].note = NOTE_W'(key_idx);
                    voice_d[v].age  = '0;
                    trig_d[v]       = 1'b1;
                end else if (voice_d[v].on && voice_q[v].age < AGE_MAX) begin
                    voice_d[v].age = voice_q[v].age + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            pend_q  <= '0;
            trig_q  <= '0;
            steal_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) voice_q[v] <= '0;
        end else begin
            prev_q  <= keys_i;
            pend_q  <= pend_d;
            trig_q  <= trig_d;
            steal_q <= steal_d;
            ovf_q   <= ovf_d;
            for (int v = 0; v < NUM_VOICES; v++) voice_q[v] <= voice_d[v];
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note_o[v*KEY_W +: KEY_W] = KEY_W'(voice_q[v].note);
            voice_on_o[v]                  = voice_q[v].on;
        end
    end

    assign voice_trig_o = trig_q;
    assign steal_o      = steal_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: a stealing and a non-stealing instance.
module tb_voice_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] keys_a, keys_b;
    logic [7:0]  note_a, note_b;
    logic [1:0]  on_a, on_b, trig_a, trig_b;
    logic        steal_a, steal_b, ovf_a, ovf_b;

    int ntests = 0;
    int nfail  = 0;
    int step   = 0;

    typedef struct {
        int         step;
        logic       sel;
        logic [3:0] n0, n1;
        logic [1:0] on, trig;
        logic       st, ov;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    voice_alloc #(.NUM_KEYS(14), .NUM_VOICES(2), .STEAL_EN(1)) dut_a (
        .clk(clk), .rst(rst), .keys_i(keys_a), .voice_note_o(note_a),
        .voice_on_o(on_a), .voice_trig_o(trig_a), .steal_o(steal_a), .overflow_o(ovf_a)
    );

    voice_alloc #(.NUM_KEYS(14), .NUM_VOICES(2), .STEAL_EN(0)) dut_b (
        .clk(clk), .rst(rst), .keys_i(keys_b), .voice_note_o(note_b),
        .voice_on_o(on_b), .voice_trig_o(trig_b), .steal_o(steal_b), .overflow_o(ovf_b)
    );

    function automatic logic [13:0] km(input int a, input int b = -1, input int c = -1);
        logic [13:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    task automatic chk(input int s, input string nm, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL step%0d %s observed=%0h expected=%0h", s, nm, obs, exp);
        end
    endtask

    // Drive one cycle of keys on the selected instance, queue the expected
    // post-edge outputs, then pop and compare after the edge.
    task automatic cyc(input logic sel, input logic [13:0] k,
                       input logic [3:0] n0, input logic [3:0] n1,
                       input logic [1:0] on, input logic [1:0] trig,
                       input logic st, input logic ov);
        exp_t e;
        if (sel) keys_b = k; else keys_a = k;
        step++;
        e = '{step: step, sel: sel, n0: n0, n1: n1, on: on, trig: trig, st: st, ov: ov};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.step, "note0", 8'(e.sel ? note_b[3:0] : note_a[3:0]), 8'(e.n0));
        chk(e.step, "note1", 8'(e.sel ? note_b[7:4] : note_a[7:4]), 8'(e.n1));
        chk(e.step, "on",    8'(e.sel ? on_b : on_a),     8'(e.on));
        chk(e.step, "trig",  8'(e.sel ? trig_b : trig_a), 8'(e.trig));
        chk(e.step, "steal", 8'(e.sel ? steal_b : steal_a), 8'(e.st));
        chk(e.step, "ovf",   8'(e.sel ? ovf_b : ovf_a),   8'(e.ov));
    endtask

    initial begin
        keys_a = '0;
        keys_b = '0;
        rst    = 1'b1;
        cyc(0, '0, 0, 0, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;

        // Single press, hold, release.
        cyc(0, km(5),        5, 0, 2'b01, 2'b01, 0, 0);
        cyc(0, km(5),        5, 0, 2'b01, 2'b00, 0, 0);
        cyc(0, '0,           5, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, '0,           5, 0, 2'b00, 2'b00, 0, 0);

        // Simultaneous presses serviced in ascending order.
        cyc(0, km(3, 9),     3, 0, 2'b01, 2'b01, 0, 0);
        cyc(0, km(3, 9),     3, 9, 2'b11, 2'b10, 0, 0);
        cyc(0, km(3, 9),     3, 9, 2'b11, 2'b00, 0, 0);

        // Third key steals the oldest voice; stolen key release is ignored.
        cyc(0, km(3, 9, 12), 12, 9, 2'b11, 2'b01, 1, 1);
        cyc(0, km(3, 9, 12), 12, 9, 2'b11, 2'b00, 0, 1);
        cyc(0, km(9, 12),    12, 9, 2'b11, 2'b00, 0, 0);

        // Release and press in one cycle reuse the freed voice without stealing.
        cyc(0, km(0, 12),    12, 0, 2'b11, 2'b10, 0, 0);
        cyc(0, km(0, 12),    12, 0, 2'b11, 2'b00, 0, 0);

        // Non-stealing instance drops the press when full.
        cyc(1, km(3, 9),     3, 0, 2'b01, 2'b01, 0, 0);
        cyc(1, km(3, 9),     3, 9, 2'b11, 2'b10, 0, 0);
        cyc(1, km(3, 9, 12), 3, 9, 2'b11, 2'b00, 0, 1);
        cyc(1, km(9, 12),    3, 9, 2'b10, 2'b00, 0, 0);
        cyc(1, km(9, 12),    3, 9, 2'b10, 2'b00, 0, 0);

        // Reset with keys held; they reappear as fresh presses afterwards.
        rst = 1'b1;
        cyc(0, km(1, 2, 4),  0, 0, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;
        cyc(0, km(1, 2, 4),  1, 0, 2'b01, 2'b01, 0, 1);
        cyc(0, km(1, 2, 4),  1, 2, 2'b11, 2'b10, 0, 1);
        cyc(0, km(1, 2, 4),  4, 2, 2'b11, 2'b01, 1, 1);
        cyc(0, km(1, 2, 4),  4, 2, 2'b11, 2'b00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
